// File: rtl/pdm_serializer_if.sv
// PCM sample handshake between a sample source and the PDM serializer.
interface pdm_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] pcm_data;
  logic                  pcm_valid;
  logic                  pcm_ready;

  modport master (output pcm_data, pcm_valid, input  pcm_ready);
  modport slave  (input  pcm_data, pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_serializer.sv
// PCM-to-PDM output path: 2-entry FWFT FIFO feeding a first-order sigma-delta
// modulator that emits OVERSAMPLE bits per sample on a divided bit clock.
module pdm_serializer #(
  parameter int DATA_WIDTH      = 16,
  parameter int SYSCLK_FREQ_MHZ = 100,
  parameter int PDM_FREQ_HZ     = 2500000,
  parameter int OVERSAMPLE      = 64
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              en,
  pdm_serializer_if.slave   pcm,
  output logic              pdm_clk,
  output logic              pdm_out,
  output logic              pdm_sd,
  output logic              sample_taken,
  output logic              underrun
);
  localparam int HALF_PERIOD = SYSCLK_FREQ_MHZ * 1000000 / (2 * PDM_FREQ_HZ);
  localparam int DIV_W       = $clog2(HALF_PERIOD + 1);
  localparam int BIT_W       = $clog2(OVERSAMPLE + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] cur_sample;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;

  logic                  push, pop, tc, bit_evt, frame_start;
  logic [1:0]            count_nxt;
  logic [DATA_WIDTH-1:0] smp, u;
  logic [DATA_WIDTH:0]   sum;

  always_comb begin
    push        = pcm.pcm_valid & pcm.pcm_ready;
    tc          = (div_cnt == DIV_W'(HALF_PERIOD - 1));
    bit_evt     = (state == RUN) && en && tc && pdm_clk;
    frame_start = bit_evt && (bit_cnt == '0);
    // pop decision uses the pre-push count, so a push into an empty FIFO is kept
    pop         = frame_start && (count != 2'd0);
    count_nxt   = count + {1'b0, push} - {1'b0, pop};
    smp         = pop ? mem[rd_ptr] : cur_sample;
    u           = {~smp[DATA_WIDTH-1], smp[DATA_WIDTH-2:0]};
    sum         = {1'b0, acc} + {1'b0, u};
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= pcm.pcm_data;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      acc           <= '0;
      cur_sample    <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      pcm.pcm_ready <= 1'b1;
      pdm_clk       <= 1'b0;
      pdm_out       <= 1'b0;
      pdm_sd        <= 1'b0;
      sample_taken  <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      pdm_sd        <= en;
      sample_taken  <= pop;
      underrun      <= frame_start && (count == 2'd0);
      count         <= count_nxt;
      pcm.pcm_ready <= (count_nxt != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          acc     <= '0;
          pdm_clk <= 1'b0;
          pdm_out <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            // cur_sample and FIFO survive a disable; everything else restarts
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            acc     <= '0;
            pdm_clk <= 1'b0;
            pdm_out <= 1'b0;
          end else begin
            if (tc) begin
              div_cnt <= '0;
              pdm_clk <= ~pdm_clk;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
            if (bit_evt) begin
              pdm_out    <= sum[DATA_WIDTH];
              acc        <= sum[DATA_WIDTH-1:0];
              cur_sample <= smp;
              bit_cnt    <= (bit_cnt == BIT_W'(OVERSAMPLE - 1)) ? '0 : bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pdm_serializer.sv
// Directed bench: scoreboard of pushed samples drives a sigma-delta reference
// checked at every PDM bit event.
module tb_pdm_serializer;
  localparam int DW = 16;
  localparam int HP = 20;
  localparam int OS = 64;

  logic HCLK = 1'b0;
  logic HRESET, en;
  logic pdm_clk, pdm_out, pdm_sd, sample_taken, underrun;

  pdm_serializer_if #(.DATA_WIDTH(DW)) pcm ();

  pdm_serializer #(
    .DATA_WIDTH(DW), .SYSCLK_FREQ_MHZ(100), .PDM_FREQ_HZ(2500000), .OVERSAMPLE(OS)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .pcm(pcm.slave),
    .pdm_clk(pdm_clk), .pdm_out(pdm_out), .pdm_sd(pdm_sd),
    .sample_taken(sample_taken), .underrun(underrun)
  );

  always #5 HCLK = ~HCLK;

  int cyc_now = 0;
  always @(posedge HCLK) cyc_now <= cyc_now + 1;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] m_cur, m_acc;
  int            m_bit;
  int            ones, ev_first, ev_prev, period, en_cyc;
  logic          bits [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    step(3);
    chk("rst_ready", pcm.pcm_ready, 1);
    chk("rst_pdm_clk", pdm_clk, 0);
    chk("rst_pdm_out", pdm_out, 0);
    chk("rst_pdm_sd", pdm_sd, 0);
    chk("rst_sample_taken", sample_taken, 0);
    chk("rst_underrun", underrun, 0);
    HRESET = 1'b0;
    en     = 1'b0;
    sb.delete();
    m_cur = '0;
    m_acc = '0;
    m_bit = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    chk("ready_before_push", pcm.pcm_ready, 1);
    pcm.pcm_data  = d;
    pcm.pcm_valid = 1'b1;
    step(1);
    pcm.pcm_valid = 1'b0;
    sb.push_back(d);
  endtask

  task automatic enable();
    en     = 1'b1;
    en_cyc = cyc_now;
  endtask

  task automatic disable_run();
    en = 1'b0;
    step(1);
    m_acc = '0;
    m_bit = 0;
  endtask

  task automatic wait_bit(output logic ok);
    logic prev;
    int   start;
    prev  = pdm_clk;
    start = cyc_now;
    ok    = 1'b0;
    while (!ok && (cyc_now - start) < 4 * HP) begin
      step(1);
      if (prev && !pdm_clk) ok = 1'b1;
      prev = pdm_clk;
    end
    if (!ok) chk("bit_event_timeout", cyc_now - start, 2 * HP);
  endtask

  // Waits for n bit events, checking each against the reference modulator.
  task automatic run_bits(input int n);
    logic          ok, st_exp, ur_exp, exp_bit;
    logic [DW-1:0] u;
    logic [DW:0]   sum;
    ones = 0;
    bits.delete();
    for (int i = 0; i < n; i++) begin
      wait_bit(ok);
      if (i == 0) ev_first = cyc_now;
      else        period   = cyc_now - ev_prev;
      ev_prev = cyc_now;
      st_exp = 1'b0;
      ur_exp = 1'b0;
      if (m_bit == 0) begin
        if (sb.size() > 0) begin
          m_cur  = sb.pop_front();
          st_exp = 1'b1;
        end else begin
          ur_exp = 1'b1;
        end
      end
      u       = m_cur + 16'h8000;
      sum     = {1'b0, m_acc} + {1'b0, u};
      exp_bit = sum[DW];
      m_acc   = sum[DW-1:0];
      m_bit   = (m_bit + 1) % OS;
      chk("pdm_out", pdm_out, exp_bit);
      chk("sample_taken", sample_taken, st_exp);
      chk("underrun", underrun, ur_exp);
      ones += int'(pdm_out);
      bits.push_back(pdm_out);
      if (st_exp || ur_exp) begin
        step(1);
        chk("pulse_width_taken", sample_taken, 0);
        chk("pulse_width_underrun", underrun, 0);
      end
    end
  endtask

  initial begin
    int ones_a;
    HRESET = 1'b1; en = 1'b0;
    pcm.pcm_valid = 1'b0; pcm.pcm_data = '0;
    step(1);

    // Reset during RUN with a full FIFO
    do_reset();
    push(16'h1111);
    push(16'h2222);
    chk("ready_full", pcm.pcm_ready, 0);
    enable();
    run_bits(1);
    push(16'h3333);
    chk("ready_full_run", pcm.pcm_ready, 0);
    do_reset();
    enable();
    run_bits(4);
    chk("post_reset_latency", ev_first - (en_cyc + 1), 2 * HP);
    chk("post_reset_bits", {bits[0], bits[1], bits[2], bits[3]}, 4'b0101);
    disable_run();

    // Idle backpressure: third word must be refused
    do_reset();
    push(16'h0001);
    push(16'h0002);
    chk("bp_ready_low", pcm.pcm_ready, 0);
    pcm.pcm_data  = 16'h0003;
    pcm.pcm_valid = 1'b1;
    step(3);
    chk("bp_ready_held_low", pcm.pcm_ready, 0);
    pcm.pcm_valid = 1'b0;
    enable();
    run_bits(OS);
    run_bits(1);
    chk("bp_queue_drained", sb.size(), 0);
    disable_run();
    chk("disable_pdm_clk", pdm_clk, 0);

    // Zero input
    do_reset();
    push(16'h0000);
    enable();
    step(1);
    chk("pdm_sd_follows_en", pdm_sd, 1);
    run_bits(OS);
    chk("zero_first4", {bits[0], bits[1], bits[2], bits[3]}, 4'b0101);
    chk("zero_ones", ones, 32);
    chk("zero_period", period, 2 * HP);
    chk("zero_latency", ev_first - (en_cyc + 1), 2 * HP);

    // Density extremes
    do_reset();
    push(16'h4000);
    enable();
    run_bits(OS);
    chk("density_4000", ones, 48);
    push(16'h8000);
    run_bits(OS);
    chk("density_8000", ones, 0);

    // Underrun: one sample, two frames
    do_reset();
    push(16'h4000);
    enable();
    run_bits(OS);
    ones_a = ones;
    run_bits(OS);
    chk("underrun_frame1_ones", ones_a, 48);
    chk("underrun_frame2_ones", ones, 48);

    // Mid-frame disable, then re-enable with a pending word
    do_reset();
    push(16'h7fff);
    enable();
    run_bits(10);
    step(HP + 2);
    chk("mid_pre_clk_high", pdm_clk, 1);
    chk("mid_pre_out_high", pdm_out, 1);
    disable_run();
    chk("mid_clk_low", pdm_clk, 0);
    chk("mid_out_low", pdm_out, 0);
    chk("mid_sd_low", pdm_sd, 0);
    push(16'h4000);
    enable();
    run_bits(OS);
    chk("reen_latency", ev_first - (en_cyc + 1), 2 * HP);
    chk("reen_ones", ones, 48);
    disable_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pdm_serializer.md
Name: pdm_serializer

Overview:
Audio-output counterpart of the microphone PDM capture path. Accepts signed PCM samples over a valid/ready handshake into a 2-entry FIFO. Converts each sample into an OVERSAMPLE-bit pulse-density stream using a first-order sigma-delta modulator. Drives the PDM bit clock and data to the board audio amplifier/filter.

Parameters:
DATA_WIDTH, 16, PCM sample width (signed two's complement).
SYSCLK_FREQ_MHZ, 100, HCLK frequency in MHz.
PDM_FREQ_HZ, 2500000, PDM bit rate. HALF_PERIOD = SYSCLK_FREQ_MHZ*1e6/(2*PDM_FREQ_HZ), which is 20 at the defaults.
OVERSAMPLE, 64, PDM bits emitted per PCM sample.

Ports:
HCLK  in  1  system clock, single clock domain
HRESET  in  1  synchronous reset, active-high
en  in  1  1 = run modulator, 0 = idle
pcm_data  in  DATA_WIDTH  signed PCM sample
pcm_valid  in  1  pcm_data valid
pcm_ready  out  1  FIFO can accept; transfer occurs when pcm_valid & pcm_ready at a HCLK edge
pdm_clk  out  1  PDM bit clock
pdm_out  out  1  PDM data, changes only with pdm_clk falling
pdm_sd  out  1  amplifier enable; equals registered en
sample_taken  out  1  1-cycle pulse when a FIFO entry is popped into the modulator
underrun  out  1  1-cycle pulse when a frame starts with the FIFO empty

Behaviour:
- Reset, with HRESET sampled high at HCLK: state IDLE; FIFO emptied; div_cnt=0; bit_cnt=0; acc=0; cur_sample=0.
- Reset output values: pcm_ready=1, pdm_clk=0, pdm_out=0, pdm_sd=0, sample_taken=0, underrun=0. Reset mid-frame aborts immediately with no partial behaviour.
- FIFO: depth 2, first-word fall-through.
  - pcm_ready = not full. It is registered from the count, so it deasserts the cycle after the 2nd push.
  - The FIFO accepts pushes in both IDLE and RUN.
  - Push and pop in the same cycle: the pop sees pre-push contents, and the push is stored.
  - If the FIFO was empty in that cycle, the pop is an underrun and the pushed word stays in the FIFO.
- FSM IDLE:
  - pdm_clk=0, pdm_out=0, div_cnt=0, bit_cnt=0, acc=0.
  - en=1 moves to RUN on the next edge.
- FSM RUN:
  - div_cnt counts 0..HALF_PERIOD-1. At the terminal count it wraps and pdm_clk toggles.
  - Bit event: the cycle in which pdm_clk toggles 1->0. The first bit event occurs 2*HALF_PERIOD cycles after entering RUN.
  - At a bit event with bit_cnt==0 and the FIFO non-empty: pop into cur_sample and pulse sample_taken. The new sample is used for this bit.
  - At a bit event with bit_cnt==0 and the FIFO empty: cur_sample holds its old value and underrun pulses.
  - bit_cnt increments at each bit event and wraps OVERSAMPLE-1 -> 0.
- Modulator, evaluated per bit event:
  - u = cur_sample + 2^(DATA_WIDTH-1), giving an unsigned offset value.
  - sum = {1'b0, acc} + u, DATA_WIDTH+1 bits.
  - pdm_out <= sum[DATA_WIDTH] on the same edge that drives pdm_clk low.
  - acc <= sum[DATA_WIDTH-1:0].
  - Ones density = u/2^DATA_WIDTH. acc is not cleared between frames.
- en deassert in RUN: on the next edge, go to IDLE.
  - pdm_clk and pdm_out go to 0 and counters/acc clear.
  - cur_sample is retained, and FIFO contents are retained.
- pdm_sd <= en every cycle, with 1-cycle latency.

Test Plan:
- Reset: assert HRESET for 3 cycles during RUN with the FIFO holding 2 entries -> next cycle pcm_ready=1, pdm_clk=0, pdm_out=0, pdm_sd=0, FIFO empty.
- Idle backpressure: en=0, push 0x0001, 0x0002, then 0x0003 with pcm_valid held.
  - pcm_ready=0 after the 2nd push, and the 3rd word is not accepted.
  - Set en=1: sample_taken fires, the first frame uses 0x0001, and at the next frame start the FIFO pops 0x0002.
- Zero input: push 0x0000, en=1 -> pdm_out over the first 4 bits = 0,1,0,1, and the frame contains exactly 32 ones. pdm_clk period = 40 HCLK cycles.
- Density: push 0x4000 from reset -> exactly 48 ones in the first 64-bit frame. Push 0x8000 -> 0 ones.
- Underrun: one sample then no more pushes -> at the 2nd frame start, underrun pulses for 1 cycle, sample_taken=0, and the same bit pattern density repeats.
- Mid-frame disable: drop en at bit 10 -> next edge pdm_clk=0, pdm_out=0. Re-enable -> bit_cnt restarts at 0, acc=0, the first bit event occurs 40 cycles after entering RUN, and a pending FIFO word is popped.
